// File: rtl/lsu_access_ctrl.sv
// lsu_access_ctrl: sequences core loads/stores onto a word-wide req/ack memory port,
// splitting misaligned accesses into two aligned words and extending load data.
module lsu_access_ctrl #(
    parameter int MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [2:0]  core_sel,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic        core_busy,
    output logic        core_done,
    output logic        core_err,
    output logic [31:0] core_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);
    localparam int CW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {IDLE, ACC1, ACC2, DONE} state_t;

    state_t        state, state_n;
    logic          we_q, to_q;
    logic [2:0]    sel_q;
    logic [31:0]   addr_q, wdata_q, w1;
    logic [CW-1:0] cnt;

    logic [1:0]  k;
    logic        is_b, is_h, split, sgn, in_acc, timeout, last_ack;
    logic [3:0]  mask;
    logic [7:0]  b8;
    logic [63:0] s64, pair;
    logic [31:0] base, r, ext;

    always_comb begin
        k        = addr_q[1:0];
        is_b     = sel_q == 3'd0 || sel_q == 3'd3;
        is_h     = sel_q == 3'd1 || sel_q == 3'd4;
        sgn      = sel_q == 3'd0 || sel_q == 3'd1;
        mask     = is_b ? 4'b0001 : is_h ? 4'b0011 : 4'b1111;
        split    = (is_h && k == 2'd3) || (!is_b && !is_h && k != 2'd0);
        s64      = {32'b0, wdata_q} << {k, 3'b000};
        b8       = {4'b0, mask} << k;
        base     = {addr_q[31:2], 2'b00};
        in_acc   = state == ACC1 || state == ACC2;
        // the MAX_WAIT-th request cycle is the last one; an ack there still completes
        timeout  = in_acc && !mem_ack && cnt == CW'(MAX_WAIT - 1);
        last_ack = mem_ack && (state == ACC2 || (state == ACC1 && !split));
        pair     = state == ACC2 ? {mem_rdata, w1} : {32'b0, mem_rdata};
        r        = 32'(pair >> {k, 3'b000});
        ext      = is_b ? {{24{sgn & r[7]}}, r[7:0]} : is_h ? {{16{sgn & r[15]}}, r[15:0]} : r;
        mem_req   = in_acc;
        mem_we    = in_acc && we_q;
        mem_addr  = state == ACC2 ? base + 32'd4 : in_acc ? base : 32'd0;
        mem_be    = !in_acc ? 4'b0000 : !we_q ? 4'b1111 : state == ACC2 ? b8[7:4] : b8[3:0];
        mem_wdata = !(in_acc && we_q) ? 32'd0 : state == ACC2 ? s64[63:32] : s64[31:0];
        core_busy = state != IDLE;
        core_done = state == DONE && !to_q;
        core_err  = state == DONE && to_q;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = core_req ? ACC1 : IDLE;
            ACC1:    state_n = mem_ack ? (split ? ACC2 : DONE) : timeout ? DONE : ACC1;
            ACC2:    state_n = (mem_ack || timeout) ? DONE : ACC2;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            sel_q      <= 3'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            w1         <= 32'd0;
            cnt        <= '0;
            to_q       <= 1'b0;
            core_rdata <= 32'd0;
        end else begin
            state <= state_n;
            to_q  <= timeout;
            cnt   <= (state_n != state || !in_acc) ? '0 : cnt + 1'b1;
            if (state == IDLE && core_req) begin
                we_q    <= core_we;
                sel_q   <= core_sel;
                addr_q  <= core_addr;
                wdata_q <= core_wdata;
            end
            if (state == ACC1 && mem_ack)
                w1 <= mem_rdata;
            if (last_ack && !we_q)
                core_rdata <= ext;
        end
    end
endmodule

// File: tb/tb_lsu_access_ctrl.sv
// tb_lsu_access_ctrl: directed load/store vectors with a queue-based scoreboard
// checking every memory handshake and every core completion.
module tb_lsu_access_ctrl;
    logic        clk = 1'b0, reset = 1'b0;
    logic        core_req = 1'b0, core_we = 1'b0;
    logic [2:0]  core_sel = 3'd0;
    logic [31:0] core_addr = 32'd0, core_wdata = 32'd0;
    logic        core_busy, core_done, core_err;
    logic [31:0] core_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ack = 1'b0;

    lsu_access_ctrl #(.MAX_WAIT(16)) dut (
        .clk(clk), .reset(reset), .core_req(core_req), .core_we(core_we),
        .core_sel(core_sel), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_busy(core_busy), .core_done(core_done), .core_err(core_err),
        .core_rdata(core_rdata), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata;} mexp_t;
    typedef struct {logic err; logic [31:0] rdata;} rexp_t;

    mexp_t       mq[$];
    rexp_t       rq_exp[$];
    int          dq[$];
    logic [31:0] rq[$];
    int          passed = 0, total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic exp_mem(input logic [31:0] a, input logic we, input logic [3:0] be, input logic [31:0] wd);
        mexp_t e;
        e.addr = a; e.we = we; e.be = be; e.wdata = wd;
        mq.push_back(e);
    endtask

    task automatic exp_resp(input logic err, input logic [31:0] rd);
        rexp_t e;
        e.err = err; e.rdata = rd;
        rq_exp.push_back(e);
    endtask

    // memory model: per-access ack delay from dq (-1 = never), read words from rq
    initial begin
        int  wcnt, cur;
        bit  active, prev;
        active = 0; wcnt = 0; cur = 0;
        forever begin
            @(posedge clk); #2;
            prev      = mem_ack;
            mem_ack   = 1'b0;
            mem_rdata = 32'hDEAD_BEEF;
            if (prev || !mem_req) active = 0;
            if (mem_req) begin
                if (!active) begin
                    active = 1; wcnt = 0;
                    cur = dq.size() != 0 ? dq.pop_front() : 0;
                end
                if (cur >= 0 && wcnt == cur) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rq.size() != 0 ? rq.pop_front() : 32'd0;
                end else wcnt++;
            end
        end
    end

    // monitor: compares handshakes and completions against queued expectations
    initial begin
        mexp_t       m;
        rexp_t       e;
        logic [31:0] lm;
        forever begin
            @(negedge clk);
            if (reset && mem_req && mem_ack) begin
                if (mq.size() == 0) chk("mem_unexpected", 32'd0, 32'd1);
                else begin
                    m = mq.pop_front();
                    chk("mem_addr", mem_addr, m.addr);
                    chk("mem_we", {31'd0, mem_we}, {31'd0, m.we});
                    chk("mem_be", {28'd0, mem_be}, {28'd0, m.be});
                    lm = {{8{m.be[3]}}, {8{m.be[2]}}, {8{m.be[1]}}, {8{m.be[0]}}};
                    if (m.we) chk("mem_wdata", mem_wdata & lm, m.wdata & lm);
                end
            end
            if (core_done || core_err) begin
                if (rq_exp.size() == 0) chk("resp_unexpected", 32'd0, 32'd1);
                else begin
                    e = rq_exp.pop_front();
                    chk("resp_err", {31'd0, core_err}, {31'd0, e.err});
                    chk("resp_done", {31'd0, core_done}, {31'd0, !e.err});
                    chk("resp_rdata", core_rdata, e.rdata);
                    chk("resp_busy", {31'd0, core_busy}, 32'd1);
                end
            end
        end
    end

    task automatic run(input logic we, input logic [2:0] sel, input logic [31:0] a,
                       input logic [31:0] wd, output int reqc);
        bit got;
        @(posedge clk); #2;
        core_req = 1'b1; core_we = we; core_sel = sel; core_addr = a; core_wdata = wd;
        @(posedge clk); #2;
        core_req = 1'b0;
        reqc = 0; got = 0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            if (mem_req) reqc++;
            if (core_done || core_err) got = 1;
        end
        if (!got) chk("completion_wait", 32'd0, 32'd1);
    endtask

    initial begin
        int reqc;
        #3;
        chk("rst_busy", {31'd0, core_busy}, 32'd0);
        chk("rst_done_err", {30'd0, core_done, core_err}, 32'd0);
        chk("rst_rdata", core_rdata, 32'd0);
        chk("rst_mem", {27'd0, mem_req, mem_be}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        dq.push_back(2); rq.push_back(32'h80AA_BBCC);
        exp_mem(32'h100, 0, 4'hF, 0); exp_resp(0, 32'hFFFF_FF80);
        run(0, 3'b000, 32'h103, 0, reqc);

        dq.push_back(1); dq.push_back(0); rq.push_back(32'h1134_5678); rq.push_back(32'h9ABC_DE22);
        exp_mem(32'h200, 0, 4'hF, 0); exp_mem(32'h204, 0, 4'hF, 0); exp_resp(0, 32'h0000_2211);
        run(0, 3'b100, 32'h203, 0, reqc);

        dq.push_back(0); dq.push_back(3);
        exp_mem(32'h300, 1, 4'b1110, 32'hB2C3_D400); exp_mem(32'h304, 1, 4'b0001, 32'h0000_00A1);
        exp_resp(0, 32'h0000_2211);
        run(1, 3'b010, 32'h301, 32'hA1B2_C3D4, reqc);

        dq.push_back(1);
        exp_mem(32'h400, 1, 4'b1100, 32'hBEEF_0000); exp_resp(0, 32'h0000_2211);
        run(1, 3'b001, 32'h402, 32'h0000_BEEF, reqc);

        dq.push_back(-1);
        exp_resp(1, 32'h0000_2211);
        run(0, 3'b010, 32'h500, 0, reqc);
        chk("timeout_req_cycles", reqc, 32'd16);
        @(negedge clk);
        chk("timeout_busy_clear", {30'd0, core_busy, mem_req}, 32'd0);

        dq.push_back(0); rq.push_back(32'h8001_1234);
        exp_mem(32'h600, 0, 4'hF, 0); exp_resp(0, 32'hFFFF_8001);
        run(0, 3'b001, 32'h602, 0, reqc);

        dq.push_back(0); rq.push_back(32'h0000_F000);
        exp_mem(32'h700, 0, 4'hF, 0); exp_resp(0, 32'h0000_00F0);
        run(0, 3'b011, 32'h701, 0, reqc);

        dq.push_back(0); rq.push_back(32'h1234_5678);
        exp_mem(32'h800, 0, 4'hF, 0); exp_resp(0, 32'h1234_5678);
        run(0, 3'b111, 32'h800, 0, reqc);

        dq.push_back(0);
        exp_mem(32'h900, 1, 4'b1000, 32'h5500_0000); exp_resp(0, 32'h1234_5678);
        run(1, 3'b000, 32'h903, 32'h1234_5655, reqc);

        dq.push_back(15); rq.push_back(32'hCAFE_F00D);
        exp_mem(32'hA00, 0, 4'hF, 0); exp_resp(0, 32'hCAFE_F00D);
        run(0, 3'b010, 32'hA00, 0, reqc);
        chk("late_ack_req_cycles", reqc, 32'd16);

        // split word load across the top of memory, reset while the second word is pending
        dq.push_back(0); dq.push_back(-1); rq.push_back(32'h1111_1111);
        exp_mem(32'hFFFF_FFFC, 0, 4'hF, 0);
        @(posedge clk); #2;
        core_req = 1'b1; core_we = 1'b0; core_sel = 3'b010; core_addr = 32'hFFFF_FFFE;
        @(posedge clk); #2;
        core_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("wrap_addr", mem_addr, 32'h0000_0000);
        chk("wrap_req_be", {27'd0, mem_req, mem_be}, 32'h1F);
        #2 reset = 1'b0;
        #1;
        chk("arst_core", {29'd0, core_busy, core_done, core_err}, 32'd0);
        chk("arst_rdata", core_rdata, 32'd0);
        chk("arst_mem_ctl", {26'd0, mem_req, mem_we, mem_be}, 32'd0);
        chk("arst_mem_addr", mem_addr, 32'd0);
        chk("arst_mem_wdata", mem_wdata, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_after_reset", {31'd0, core_busy}, 32'd0);
        chk("mem_queue_drained", mq.size(), 32'd0);
        chk("resp_queue_drained", rq_exp.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
